// File: rtl/mul_share_arbiter_pkg.sv
// Shared types and constants for the multiplier-sharing arbiter.
// Used by mul_share_arbiter and mul_share_pick.
package mul_share_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

  localparam int ID_W  = 1;
  localparam int CNT_W = 4;

  typedef logic [ID_W-1:0]  req_id_t;
  typedef logic [CNT_W-1:0] settle_cnt_t;

endpackage

// File: rtl/mul_share_pick.sv
// Two-way combinational grant for the shared multiplier.
// MUL_SHARE_RR_EN selects round-robin tie-breaking; otherwise requester 0 always wins ties.
module mul_share_pick
  import mul_share_arbiter_pkg::*;
(
  input  logic [1:0] valid,
`ifdef MUL_SHARE_RR_EN
  input  req_id_t    last_grant,
`endif
  output logic [1:0] grant
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
`ifdef MUL_SHARE_RR_EN
      grant = (last_grant == req_id_t'(1)) ? 2'b01 : 2'b10;
`else
      grant = 2'b01;
`endif
    end
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Sequences two requesters onto one external 16x16 multiplier and returns each product.
// Optional round-robin arbitration via MUL_SHARE_RR_EN (fixed priority to requester 0 otherwise).
module mul_share_arbiter
  import mul_share_arbiter_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int SETTLE = 1
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iReq0_Valid,
  input  logic [WIDTH-1:0]   iReq0_A,
  input  logic [WIDTH-1:0]   iReq0_B,
  input  logic               iReq1_Valid,
  input  logic [WIDTH-1:0]   iReq1_A,
  input  logic [WIDTH-1:0]   iReq1_B,
  output logic               oReq0_Ready,
  output logic               oReq1_Ready,
  output logic               oRsp0_Valid,
  output logic               oRsp1_Valid,
  output logic [2*WIDTH-1:0] oRsp0_Result,
  output logic [2*WIDTH-1:0] oRsp1_Result,
  input  logic               iRsp0_Ready,
  input  logic               iRsp1_Ready,
  output logic [WIDTH-1:0]   oMul_A,
  output logic [WIDTH-1:0]   oMul_B,
  input  logic [2*WIDTH-1:0] iMul_Result,
  output logic               oBusy
);

  localparam settle_cnt_t SETTLE_LOAD = settle_cnt_t'(SETTLE - 1);

  state_t             state;
  req_id_t            req_id;
  settle_cnt_t        cnt;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [2*WIDTH-1:0] result;

  logic [1:0] grant;
  logic [1:0] ready;
  logic       accept;
  req_id_t    accept_id;
  logic       rsp_fire;

`ifdef MUL_SHARE_RR_EN
  req_id_t last_grant;

  mul_share_pick u_pick (
    .valid      ({iReq1_Valid, iReq0_Valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Pointer starts at 1 so requester 0 wins the first tie; it moves only on an accepted handshake.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      last_grant <= req_id_t'(1);
    end else if (accept) begin
      last_grant <= accept_id;
    end
  end
`else
  mul_share_pick u_pick (
    .valid (({iReq1_Valid, iReq0_Valid})),
    .grant (grant)
  );
`endif

  assign ready     = {iReq1_Valid, iReq0_Valid} & grant & {2{state == ST_IDLE}};
  assign accept    = |ready;
  assign accept_id = req_id_t'(ready[1]);
  assign rsp_fire  = (state == ST_RESPOND) &&
                     ((req_id == req_id_t'(0)) ? iRsp0_Ready : iRsp1_Ready);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state  <= ST_IDLE;
      req_id <= '0;
      cnt    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_a   <= ready[1] ? iReq1_A : iReq0_A;
            op_b   <= ready[1] ? iReq1_B : iReq0_B;
            req_id <= accept_id;
            cnt    <= SETTLE_LOAD;
            state  <= ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          // Operands have been stable on the multiplier for SETTLE cycles when cnt reaches 0.
          if (cnt == '0) begin
            result <= iMul_Result;
            state  <= ST_RESPOND;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESPOND: begin
          if (rsp_fire) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign oReq0_Ready  = ready[0];
  assign oReq1_Ready  = ready[1];
  assign oRsp0_Valid  = (state == ST_RESPOND) && (req_id == req_id_t'(0));
  assign oRsp1_Valid  = (state == ST_RESPOND) && (req_id == req_id_t'(1));
  assign oRsp0_Result = result;
  assign oRsp1_Result = result;
  assign oMul_A       = op_a;
  assign oMul_B       = op_b;
  assign oBusy        = (state != ST_IDLE);

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Scoreboard bench for mul_share_arbiter: SETTLE=1 instance with a combinational multiplier
// and a SETTLE=4 instance whose multiplier product arrives one cycle late.
`timescale 1ns/1ps
module tb_mul_share_arbiter;

  localparam int W = 16;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  always #5 Clock = ~Clock;

  // SETTLE=1 instance
  logic           iReq0_Valid = 0, iReq1_Valid = 0;
  logic [W-1:0]   iReq0_A = '0, iReq0_B = '0, iReq1_A = '0, iReq1_B = '0;
  logic           oReq0_Ready, oReq1_Ready, oRsp0_Valid, oRsp1_Valid;
  logic [2*W-1:0] oRsp0_Result, oRsp1_Result;
  logic           iRsp0_Ready = 0, iRsp1_Ready = 0;
  logic [W-1:0]   oMul_A, oMul_B;
  logic [2*W-1:0] iMul_Result;
  logic           oBusy;

  assign iMul_Result = {{W{1'b0}}, oMul_A} * {{W{1'b0}}, oMul_B};

  mul_share_arbiter #(.WIDTH(W), .SETTLE(1)) dut (
    .Clock(Clock), .Reset(Reset),
    .iReq0_Valid(iReq0_Valid), .iReq0_A(iReq0_A), .iReq0_B(iReq0_B),
    .iReq1_Valid(iReq1_Valid), .iReq1_A(iReq1_A), .iReq1_B(iReq1_B),
    .oReq0_Ready(oReq0_Ready), .oReq1_Ready(oReq1_Ready),
    .oRsp0_Valid(oRsp0_Valid), .oRsp1_Valid(oRsp1_Valid),
    .oRsp0_Result(oRsp0_Result), .oRsp1_Result(oRsp1_Result),
    .iRsp0_Ready(iRsp0_Ready), .iRsp1_Ready(iRsp1_Ready),
    .oMul_A(oMul_A), .oMul_B(oMul_B), .iMul_Result(iMul_Result),
    .oBusy(oBusy)
  );

  // SETTLE=4 instance, requester 0 only
  logic           d4_valid = 0;
  logic [W-1:0]   d4_a = '0, d4_b = '0;
  logic           d4_ready, d4_rsp_valid, d4_r1_ready, d4_rsp1_valid;
  logic [2*W-1:0] d4_result, d4_rsp1_result;
  logic           d4_rsp_ready = 0;
  logic [W-1:0]   d4_mul_a, d4_mul_b;
  logic [2*W-1:0] d4_mul_res = '0;
  logic           d4_busy;

  always @(posedge Clock) d4_mul_res <= {{W{1'b0}}, d4_mul_a} * {{W{1'b0}}, d4_mul_b};

  mul_share_arbiter #(.WIDTH(W), .SETTLE(4)) dut4 (
    .Clock(Clock), .Reset(Reset),
    .iReq0_Valid(d4_valid), .iReq0_A(d4_a), .iReq0_B(d4_b),
    .iReq1_Valid(1'b0), .iReq1_A(16'h0), .iReq1_B(16'h0),
    .oReq0_Ready(d4_ready), .oReq1_Ready(d4_r1_ready),
    .oRsp0_Valid(d4_rsp_valid), .oRsp1_Valid(d4_rsp1_valid),
    .oRsp0_Result(d4_result), .oRsp1_Result(d4_rsp1_result),
    .iRsp0_Ready(d4_rsp_ready), .iRsp1_Ready(1'b0),
    .oMul_A(d4_mul_a), .oMul_B(d4_mul_b), .iMul_Result(d4_mul_res),
    .oBusy(d4_busy)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [31:0] q0[$], q1[$], q4[$];
  int          grant_log[$];
  int          grant_cyc[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge Clock) cyc++;

  // Scoreboard: push expected product on request handshake, compare on response handshake.
  always @(negedge Clock) begin
    if (Reset) begin
      if (iReq0_Valid && oReq0_Ready) begin
        q0.push_back(32'(iReq0_A) * 32'(iReq0_B));
        grant_log.push_back(0);
        grant_cyc.push_back(cyc);
      end
      if (iReq1_Valid && oReq1_Ready) begin
        q1.push_back(32'(iReq1_A) * 32'(iReq1_B));
        grant_log.push_back(1);
        grant_cyc.push_back(cyc);
      end
      if (d4_valid && d4_ready) q4.push_back(32'(d4_a) * 32'(d4_b));
      if (oRsp0_Valid && iRsp0_Ready) begin
        if (q0.size() == 0) check("rsp0_unexpected", 1, 0);
        else check("rsp0_result", oRsp0_Result, q0.pop_front());
      end
      if (oRsp1_Valid && iRsp1_Ready) begin
        if (q1.size() == 0) check("rsp1_unexpected", 1, 0);
        else check("rsp1_result", oRsp1_Result, q1.pop_front());
      end
      if (d4_rsp_valid && d4_rsp_ready) begin
        if (q4.size() == 0) check("rsp4_unexpected", 1, 0);
        else check("rsp4_result", d4_result, q4.pop_front());
      end
    end
  end

  function automatic logic req_ready(input int id);
    return (id == 0) ? oReq0_Ready : (id == 1) ? oReq1_Ready : d4_ready;
  endfunction

  function automatic logic rsp_valid(input int id);
    return (id == 0) ? oRsp0_Valid : (id == 1) ? oRsp1_Valid : d4_rsp_valid;
  endfunction

  task automatic set_req(input int id, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    if (id == 0) begin iReq0_Valid = v; iReq0_A = a; iReq0_B = b; end
    else if (id == 1) begin iReq1_Valid = v; iReq1_A = a; iReq1_B = b; end
    else begin d4_valid = v; d4_a = a; d4_b = b; end
  endtask

  // lat = edges from the start of the Ready cycle until response Valid is visible.
  task automatic issue(input int id, input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    int k;
    lat = -1;
    @(posedge Clock); #1;
    set_req(id, 1'b1, a, b);
    k = 0;
    while (k < 50) begin
      @(negedge Clock);
      if (req_ready(id)) break;
      k++;
    end
    if (k >= 50) begin
      check("issue_ready_timeout", 1, 0);
      set_req(id, 1'b0, a, b);
      return;
    end
    for (int n = 1; n <= 50; n++) begin
      @(posedge Clock);
      if (n == 1) begin #1; set_req(id, 1'b0, a, b); end
      @(negedge Clock);
      if (rsp_valid(id)) begin lat = n; return; end
    end
    check("issue_rsp_timeout", 1, 0);
  endtask

  task automatic consume(input int id);
    @(posedge Clock); #1;
    if (id == 0) iRsp0_Ready = 1; else if (id == 1) iRsp1_Ready = 1; else d4_rsp_ready = 1;
    @(posedge Clock); #1;
    iRsp0_Ready = 0; iRsp1_Ready = 0; d4_rsp_ready = 0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (oBusy && k < 50) begin @(negedge Clock); k++; end
    if (k >= 50) check(tag, 1, 0);
  endtask

  logic [31:0] exp_bp;
  int          lat;
  int          k;
  int          exp_g;
  logic        stale;

  initial begin
    // Reset state
    #1;
    check("rst_ready0", oReq0_Ready, 0);
    check("rst_ready1", oReq1_Ready, 0);
    check("rst_rsp0",   oRsp0_Valid, 0);
    check("rst_rsp1",   oRsp1_Valid, 0);
    check("rst_busy",   oBusy, 0);
    check("rst_mul",    {oMul_A, oMul_B}, 0);
    check("rst_result", oRsp0_Result, 0);
    repeat (2) @(negedge Clock);
    Reset = 1;

    // Single request, SETTLE=1
    issue(0, 16'h0003, 16'h0005, lat);
    check("lat_settle1", lat, 2);
    check("single_result", oRsp0_Result, 32'h0000000F);
    check("single_rsp1_low", oRsp1_Valid, 0);
    check("single_busy", oBusy, 1);
    consume(0);
    check("single_idle", oBusy, 0);

    // Corner operands
    issue(0, 16'hFFFF, 16'hFFFF, lat);
    check("max_result", oRsp0_Result, 32'hFFFE0001);
    consume(0);
    issue(0, 16'h1234, 16'h0000, lat);
    check("zero_result", oRsp0_Result, 32'h00000000);
    consume(0);

    // Backpressure on requester 1 with requester 0 pending
    exp_bp = 32'(16'hABCD) * 32'(16'h0123);
    issue(1, 16'hABCD, 16'h0123, lat);
    @(posedge Clock); #1;
    set_req(0, 1'b1, 16'h0007, 16'h0009);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      check("bp_rsp1_valid", oRsp1_Valid, 1);
      check("bp_result",     oRsp1_Result, exp_bp);
      check("bp_ready0",     oReq0_Ready, 0);
      check("bp_ready1",     oReq1_Ready, 0);
      check("bp_busy",       oBusy, 1);
    end
    consume(1);
    k = 0;
    while (!oReq0_Ready && k < 20) begin @(negedge Clock); k++; end
    check("bp_req0_granted", oReq0_Ready, 1);
    @(posedge Clock); #1;
    set_req(0, 1'b0, 16'h0007, 16'h0009);
    k = 0;
    while (!oRsp0_Valid && k < 20) begin @(negedge Clock); k++; end
    check("bp_rsp0_valid", oRsp0_Valid, 1);
    consume(0);

    // Wide product bit above the operand width; leaves last grant on requester 1
    issue(1, 16'h8000, 16'h0002, lat);
    check("wide_result", oRsp1_Result, 32'h00010000);
    consume(1);

    // Tie with both requesters continuously valid and always ready
    grant_log.delete();
    grant_cyc.delete();
    @(posedge Clock); #1;
    set_req(0, 1'b1, 16'h0011, 16'h0022);
    set_req(1, 1'b1, 16'h0303, 16'h0404);
    iRsp0_Ready = 1; iRsp1_Ready = 1;
    k = 0;
    while (k < 60) begin
      @(negedge Clock);
      if (grant_log.size() >= 4) begin
        @(posedge Clock); #1;
        iReq0_Valid = 0; iReq1_Valid = 0;
        break;
      end
      k++;
    end
    wait_idle("tie_idle_timeout");
    @(posedge Clock); #1;
    iRsp0_Ready = 0; iRsp1_Ready = 0;
    check("tie_grant_count", grant_log.size(), 4);
    if (grant_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
`ifdef MUL_SHARE_RR_EN
        exp_g = i % 2;
`else
        exp_g = 0;
`endif
        check($sformatf("tie_grant%0d", i), grant_log[i], exp_g);
        if (i > 0) check($sformatf("tie_interval%0d", i), grant_cyc[i] - grant_cyc[i-1], 3);
      end
    end
    check("tie_q_empty", q0.size() + q1.size(), 0);

    // Reset during COMPUTE
    @(posedge Clock); #1;
    set_req(0, 1'b1, 16'h0005, 16'h0007);
    k = 0;
    while (!oReq0_Ready && k < 20) begin @(negedge Clock); k++; end
    @(posedge Clock); #1;
    set_req(0, 1'b0, 16'h0005, 16'h0007);
    check("pre_rst_busy", oBusy, 1);
    #2 Reset = 0;
    #1;
    check("mid_rst_busy",   oBusy, 0);
    check("mid_rst_rsp",    {oRsp0_Valid, oRsp1_Valid}, 0);
    check("mid_rst_ready",  {oReq0_Ready, oReq1_Ready}, 0);
    check("mid_rst_mul",    {oMul_A, oMul_B}, 0);
    check("mid_rst_result", oRsp0_Result, 0);
    q0.delete();
    @(negedge Clock);
    Reset = 1;
    stale = 0;
    repeat (4) begin
      @(negedge Clock);
      stale = stale | oRsp0_Valid | oRsp1_Valid | oBusy;
    end
    check("no_stale_rsp", stale, 0);
    issue(0, 16'h0009, 16'h0009, lat);
    check("post_rst_lat", lat, 2);
    check("post_rst_result", oRsp0_Result, 32'h00000051);
    consume(0);

    // SETTLE=4 with one-cycle-late multiplier product
    issue(2, 16'h0F0F, 16'h1234, lat);
    check("lat_settle4", lat, 5);
    check("settle4_result", d4_result, 32'(16'h0F0F) * 32'(16'h1234));
    consume(2);

    repeat (2) @(negedge Clock);
    check("final_q_empty", q0.size() + q1.size() + q4.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
